// File: rtl/phy_lane_scheduler_if.sv
// Lane-side and serializer-side signal bundle for phy_lane_scheduler.
// drop_cnt exists only when PHY_SCHED_DROPCNT_EN is defined.
interface phy_lane_scheduler_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] In0, In1, In2, In3;
  logic              valid0, valid1, valid2, valid3;
  logic              ready0, ready1, ready2, ready3;
  logic              retrain;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [1:0]        lane_id;
  logic              phy_active;
`ifdef PHY_SCHED_DROPCNT_EN
  logic [7:0]        drop_cnt;
`endif

  modport master (
    output In0, In1, In2, In3, valid0, valid1, valid2, valid3, retrain, out_ready,
    input  ready0, ready1, ready2, ready3, data_out, valid_out, lane_id, phy_active
`ifdef PHY_SCHED_DROPCNT_EN
    , input drop_cnt
`endif
  );

  modport slave (
    input  In0, In1, In2, In3, valid0, valid1, valid2, valid3, retrain, out_ready,
    output ready0, ready1, ready2, ready3, data_out, valid_out, lane_id, phy_active
`ifdef PHY_SCHED_DROPCNT_EN
    , output drop_cnt
`endif
  );
endinterface

// File: rtl/phy_lane_scheduler.sv
// 4-lane PHY transmit scheduler: per-lane FIFOs, COM-symbol link training, round-robin grant.
// Optional saturating drop counter enabled by defining PHY_SCHED_DROPCNT_EN.
module phy_lane_scheduler #(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] COM_SYM    = 8'hBC,
  parameter int                TRAIN_CNT  = 4,
  parameter int                FIFO_DEPTH = 2
) (
  input logic              clk_4f,
  input logic              reset,
  phy_lane_scheduler_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TRAIN_CNT + 1);

  typedef enum logic {ST_TRAIN, ST_ACTIVE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     tcnt_q, tcnt_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        lane_q, lane_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              vout_q, vout_d;

  logic [DATA_W-1:0] mem_q [4][FIFO_DEPTH];
  logic [AW-1:0]     rd_q [4];
  logic [AW-1:0]     wr_q [4];
  logic [AW:0]       cnt_q [4];
  logic [AW:0]       cnt_d [4];
  logic [3:0]        ready_q;

  logic [DATA_W-1:0] lane_data [4];
  logic [3:0]        lane_valid;
  logic [3:0]        empty, full, push, pop, drop;
  logic              load_ok, found;
  logic [1:0]        cand, gnt;

  assign lane_data[0] = bus.In0;
  assign lane_data[1] = bus.In1;
  assign lane_data[2] = bus.In2;
  assign lane_data[3] = bus.In3;
  assign lane_valid   = {bus.valid3, bus.valid2, bus.valid1, bus.valid0};
  assign load_ok      = !vout_q || bus.out_ready;

  always_comb begin
    for (int unsigned l = 0; l < 4; l++) begin
      empty[l] = (cnt_q[l] == '0);
      full[l]  = (cnt_q[l] == (AW+1)'(FIFO_DEPTH));
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    ptr_d   = ptr_q;
    lane_d  = lane_q;
    dout_d  = dout_q;
    vout_d  = vout_q;
    pop     = '0;
    found   = 1'b0;
    cand    = '0;
    gnt     = '0;
    if (bus.retrain) begin
      state_d = ST_TRAIN;
      tcnt_d  = '0;
      dout_d  = COM_SYM;
      vout_d  = 1'b0;
    end else begin
      case (state_q)
        ST_TRAIN: begin
          dout_d = COM_SYM;
          vout_d = 1'b0;
          if (bus.out_ready) begin
            tcnt_d = tcnt_q + 1'b1;
            if (tcnt_d == CW'(TRAIN_CNT)) state_d = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (load_ok) begin
            // k=4 wraps to ptr itself, so the last-granted lane is searched last
            for (int unsigned k = 1; k <= 4; k++) begin
              cand = ptr_q + 2'(k);
              if (!found && !empty[cand]) begin
                found = 1'b1;
                gnt   = cand;
              end
            end
            if (found) begin
              pop[gnt] = 1'b1;
              dout_d   = mem_q[gnt][rd_q[gnt]];
              vout_d   = 1'b1;
              lane_d   = gnt;
              ptr_d    = gnt;
            end else begin
              dout_d = COM_SYM;
              vout_d = 1'b0;
            end
          end
        end
        default: state_d = ST_TRAIN;
      endcase
    end
  end

  // Pops only ever see pre-edge occupancy, so a same-cycle write never bypasses its FIFO.
  always_comb begin
    for (int unsigned l = 0; l < 4; l++) begin
      push[l]  = lane_valid[l] && !bus.retrain && (!full[l] || pop[l]);
      drop[l]  = lane_valid[l] && !bus.retrain && full[l] && !pop[l];
      cnt_d[l] = bus.retrain ? '0 : cnt_q[l] + (AW+1)'(push[l]) - (AW+1)'(pop[l]);
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q <= ST_TRAIN;
      tcnt_q  <= '0;
      ptr_q   <= 2'd3;
      lane_q  <= '0;
      dout_q  <= COM_SYM;
      vout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      ptr_q   <= ptr_d;
      lane_q  <= lane_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      for (int unsigned l = 0; l < 4; l++) begin
        rd_q[l]  <= '0;
        wr_q[l]  <= '0;
        cnt_q[l] <= '0;
      end
      ready_q <= '1;
    end else begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (bus.retrain) begin
          rd_q[l] <= '0;
          wr_q[l] <= '0;
        end else begin
          if (push[l]) wr_q[l] <= wr_q[l] + 1'b1;
          if (pop[l])  rd_q[l] <= rd_q[l] + 1'b1;
        end
        cnt_q[l]   <= cnt_d[l];
        ready_q[l] <= (cnt_d[l] != (AW+1)'(FIFO_DEPTH));
      end
    end
  end

  always_ff @(posedge clk_4f) begin
    for (int unsigned l = 0; l < 4; l++) begin
      if (push[l]) mem_q[l][wr_q[l]] <= lane_data[l];
    end
  end

`ifdef PHY_SCHED_DROPCNT_EN
  logic [7:0] drop_q, drop_d;
  logic [8:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_q} + 9'(drop[0]) + 9'(drop[1]) + 9'(drop[2]) + 9'(drop[3]);
    if (bus.retrain)      drop_d = '0;
    else if (drop_sum[8]) drop_d = '1;
    else                  drop_d = drop_sum[7:0];
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign bus.drop_cnt = drop_q;
`else
  logic unused_drop;
  assign unused_drop = ^drop;
`endif

  assign bus.ready0     = ready_q[0];
  assign bus.ready1     = ready_q[1];
  assign bus.ready2     = ready_q[2];
  assign bus.ready3     = ready_q[3];
  assign bus.data_out   = dout_q;
  assign bus.valid_out  = vout_q;
  assign bus.lane_id    = lane_q;
  assign bus.phy_active = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_phy_lane_scheduler.sv
// Randomized scoreboard bench for phy_lane_scheduler against a queue-based reference model.
// Compares drop_cnt only when PHY_SCHED_DROPCNT_EN is defined.
module tb_phy_lane_scheduler;

  localparam int         DATA_W     = 8;
  localparam logic [7:0] COM        = 8'hBC;
  localparam int         TRAIN_CNT  = 4;
  localparam int         FIFO_DEPTH = 2;

  typedef struct packed {
    logic [7:0] dout;
    logic       vout;
    logic [1:0] lane;
    logic       act;
    logic [3:0] rdy;
    logic [7:0] drop;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  phy_lane_scheduler_if #(.DATA_W(DATA_W)) bus ();

  phy_lane_scheduler #(
    .DATA_W(DATA_W), .COM_SYM(COM), .TRAIN_CNT(TRAIN_CNT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_4f(clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  // Reference model state
  logic [7:0] mq[4][$];
  bit         m_active;
  int         m_cnt, m_ptr, m_lane, m_drop;
  logic [7:0] m_dout;
  bit         m_vout;

  // Inputs applied in the current cycle
  logic [7:0] s_d[4];
  logic [3:0] s_v;
  logic       s_ordy, s_rt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int l = 0; l < 4; l++) mq[l].delete();
    m_active = 0; m_cnt = 0; m_ptr = 3; m_lane = 0; m_drop = 0;
    m_dout = COM; m_vout = 0;
  endtask

  task automatic m_step();
    int  drops = 0;
    bit  granted = 0;
    int  l;
    if (s_rt) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      m_active = 0; m_cnt = 0; m_vout = 0; m_dout = COM; m_drop = 0;
    end else begin
      if (!m_active) begin
        m_dout = COM; m_vout = 0;
        if (s_ordy) begin
          m_cnt++;
          if (m_cnt == TRAIN_CNT) m_active = 1;
        end
      end else if (!m_vout || s_ordy) begin
        for (int k = 1; k <= 4; k++) begin
          l = (m_ptr + k) % 4;
          if (!granted && mq[l].size() > 0) begin
            m_dout = mq[l].pop_front();
            m_vout = 1; m_lane = l; m_ptr = l; granted = 1;
          end
        end
        if (!granted) begin m_dout = COM; m_vout = 0; end
      end
      for (int i = 0; i < 4; i++)
        if (s_v[i]) begin
          if (mq[i].size() < FIFO_DEPTH) mq[i].push_back(s_d[i]);
          else drops++;
        end
      m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
    end
  endtask

  function automatic exp_t m_expect();
    exp_t e;
    e.dout = m_dout; e.vout = m_vout; e.lane = 2'(m_lane); e.act = m_active;
    for (int l = 0; l < 4; l++) e.rdy[l] = (mq[l].size() < FIFO_DEPTH);
    e.drop = 8'(m_drop);
    return e;
  endfunction

  task automatic drive();
    bus.In0 = s_d[0]; bus.In1 = s_d[1]; bus.In2 = s_d[2]; bus.In3 = s_d[3];
    bus.valid0 = s_v[0]; bus.valid1 = s_v[1]; bus.valid2 = s_v[2]; bus.valid3 = s_v[3];
    bus.out_ready = s_ordy; bus.retrain = s_rt;
  endtask

  // Asynchronous reset applied between edges, checked before the next edge
  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    s_v = '0; s_rt = 1'b0; s_ordy = 1'b0;
    drive();
    m_reset();
    #1;
    chk("async_reset_valid_out", int'(bus.valid_out), 0);
    chk("async_reset_data_out", int'(bus.data_out), int'(COM));
    chk("async_reset_ready", int'({bus.ready3, bus.ready2, bus.ready1, bus.ready0}), 15);
    sb_q.push_back(m_expect());
    repeat (cycles - 1) begin
      @(negedge clk);
      sb_q.push_back(m_expect());
    end
  endtask

  task automatic cycle(input int vp, input logic [3:0] mask, input int rp, input int rtp);
    @(negedge clk);
    reset = 1'b0;
    for (int l = 0; l < 4; l++) begin
      s_d[l] = 8'($urandom);
      s_v[l] = mask[l] && ($urandom_range(99) < vp);
    end
    s_ordy = ($urandom_range(99) < rp);
    s_rt   = ($urandom_range(999) < rtp);
    drive();
    m_step();
    sb_q.push_back(m_expect());
  endtask

  task automatic all_lanes_once();
    @(negedge clk);
    reset = 1'b0;
    s_d[0] = 8'hFF; s_d[1] = 8'hEE; s_d[2] = 8'hDD; s_d[3] = 8'hCC;
    s_v = 4'hF; s_ordy = 1'b1; s_rt = 1'b0;
    drive();
    m_step();
    sb_q.push_back(m_expect());
  endtask

  // Monitor: one expectation is consumed after every active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("data_out", int'(bus.data_out), int'(e.dout));
        chk("valid_out", int'(bus.valid_out), int'(e.vout));
        chk("lane_id", int'(bus.lane_id), int'(e.lane));
        chk("phy_active", int'(bus.phy_active), int'(e.act));
        chk("ready", int'({bus.ready3, bus.ready2, bus.ready1, bus.ready0}), int'(e.rdy));
`ifdef PHY_SCHED_DROPCNT_EN
        chk("drop_cnt", int'(bus.drop_cnt), int'(e.drop));
`endif
      end
    end
  end

  initial begin
    int waited;
    reset = 1'b1;
    s_v = '0; s_ordy = 1'b0; s_rt = 1'b0;
    for (int l = 0; l < 4; l++) s_d[l] = '0;
    drive();
    m_reset();

    do_reset(3);
    repeat (6) cycle(0, 4'h0, 100, 0);          // training, then idle COM
    all_lanes_once();                            // FF,EE,DD,CC in lane order
    repeat (6) cycle(0, 4'h0, 100, 0);
    repeat (20) cycle(100, 4'b0100, 100, 0);     // lane 2 streaming
    repeat (10) cycle(60, 4'hF, 0, 0);           // backpressure fills FIFOs
    repeat (8) cycle(0, 4'h0, 100, 0);
    repeat (300) cycle(40, 4'hF, 60, 20);
    do_reset(2);
    repeat (6) cycle(100, 4'hF, 100, 0);         // writes during training
    repeat (200) cycle(90, 4'hF, 30, 10);
    repeat (100) cycle(100, 4'hF, 0, 0);         // drop counter saturation
    repeat (5) cycle(0, 4'h0, 100, 1000);        // retrain held with full FIFOs
    repeat (100) cycle(50, 4'hF, 80, 5);

    waited = 0;
    while (sb_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
